// File: rtl/mux_scan_seq.sv
// mux_scan_seq
// Registered N-channel, WIDTH-bit multiplexer with a direct-select mode and
// an ascending scan mode over a latched channel-enable mask.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   D        packed channel data, channel k = D[k*WIDTH +: WIDTH]
//   sel      channel select used in direct mode
//   mode     0 = direct, 1 = scan
//   start    single-cycle scan request, honoured only in IDLE with mode=1
//   en_mask  channels visited by a scan, latched when start is accepted
//   Y        registered selected data
//   ch_out   index of the channel currently on Y
//   valid    Y/ch_out hold a fresh sample this cycle
//   done     one-cycle pulse that ends a scan
//   busy     high while the FSM is in SCAN
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | direct mode muxing, or waiting for a scan start
// SCAN   | walking the remaining mask, one enabled channel per cycle

module mux_scan_seq #(
    parameter  int WIDTH = 8,
    parameter  int CH    = 16,
    localparam int SELW  = $clog2(CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH*WIDTH-1:0]   D,
    input  logic [SELW-1:0]       sel,
    input  logic                  mode,
    input  logic                  start,
    input  logic [CH-1:0]         en_mask,
    output logic [WIDTH-1:0]      Y,
    output logic [SELW-1:0]       ch_out,
    output logic                  valid,
    output logic                  done,
    output logic                  busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CH-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [SELW-1:0]  ch_q, ch_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] d_ch [CH];

    logic [CH-1:0]    pe_in;
    logic [CH-1:0]    pe_clr;
    logic [SELW-1:0]  pe_idx;
    logic             pe_any;

    always_comb begin
        for (int k = 0; k < CH; k++) begin
            d_ch[k] = D[k*WIDTH +: WIDTH];
        end
    end

    // The encoder looks at the live mask when a scan is being accepted and at
    // the remaining mask while scanning; one encoder serves both cases.
    assign pe_in  = (state_q == S_SCAN) ? rem_q : en_mask;
    assign pe_any = |pe_in;

    // Descending loop so the lowest set bit is the last (winning) assignment.
    always_comb begin
        pe_idx = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (pe_in[i]) begin
                pe_idx = SELW'(i);
            end
        end
        pe_clr         = pe_in;
        pe_clr[pe_idx] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        y_d     = y_q;
        ch_d    = ch_q;
        valid_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!mode) begin
                    y_d     = d_ch[sel];
                    ch_d    = sel;
                    valid_d = 1'b1;
                end else if (start) begin
                    if (!pe_any) begin
                        // Empty mask: finish immediately without a sample.
                        done_d = 1'b1;
                    end else begin
                        y_d     = d_ch[pe_idx];
                        ch_d    = pe_idx;
                        valid_d = 1'b1;
                        rem_d   = pe_clr;
                        if (pe_clr == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = S_SCAN;
                        end
                    end
                end
            end

            S_SCAN: begin
                // rem_q is never empty here, so pe_idx always names a real bit.
                y_d     = d_ch[pe_idx];
                ch_d    = pe_idx;
                valid_d = 1'b1;
                rem_d   = pe_clr;
                if (pe_clr == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                rem_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            y_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            y_q     <= y_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign Y      = y_q;
    assign ch_out = ch_q;
    assign valid  = valid_q;
    assign done   = done_q;
    assign busy   = (state_q == S_SCAN);

endmodule
